// File: rtl/prog_sequencer.sv
// prog_sequencer: run-control sequencer for the single-issue core.
// Owns the PC, stalls multi-cycle loads, detects halt, and produces the
// Mealy Commit strobe that gates every architectural write.
module prog_sequencer #(
  parameter int         PC_W     = 10,
  parameter int         START_PC = 0,
  parameter logic [4:0] HALT_OP  = 5'b00110,
  parameter int         LOAD_LAT = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [4:0]      Opcode,
  input  logic            Load,
  input  logic            Branch,
  input  logic            Taken,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            Commit,
  output logic            Ack,
  output logic [31:0]     Cycle_Count,
  output logic [31:0]     Instr_Count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Load latency fits in 3 bits (0..7); a zero latency disables the stall.
  localparam logic [2:0]      LAT_C   = 3'(LOAD_LAT);
  localparam logic            HAS_LAT = (LOAD_LAT != 0);
  localparam logic [PC_W-1:0] START_C = PC_W'(START_PC);
  localparam logic [PC_W-1:0] ONE_C   = PC_W'(1);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_ack;
  logic [31:0]     r_cycle_count;
  logic [31:0]     r_instr_count;
  logic [2:0]      r_wait_cnt;

  logic            w_is_halt;
  logic            w_stall_load;
  logic            w_branch_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_commit;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  assign w_is_halt      = (Opcode == HALT_OP);
  assign w_stall_load   = Load && HAS_LAT;
  assign w_branch_taken = Branch && Taken;
  assign w_pc_inc       = r_pc + ONE_C;   // wraps modulo 2^PC_W

  // Commit: instruction completes in the current cycle; forced low in reset.
  always_comb begin
    w_commit = 1'b0;
    if (Reset) begin
      w_commit = 1'b0;
    end else begin
      case (r_state)
        S_RUN:   w_commit = !w_is_halt && !w_stall_load;
        S_WAIT:  w_commit = (r_wait_cnt == 3'd1);
        default: w_commit = 1'b0;
      endcase
    end
  end

  // Run-control state machine, program counter and performance counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ack         <= 1'b0;
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
      r_wait_cnt    <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_pc          <= START_C;
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycle_count <= sat_inc(r_cycle_count);
          if (w_is_halt) begin
            // Halt is not counted; PC stays on the halt instruction.
            r_ack   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_stall_load) begin
            r_wait_cnt <= LAT_C;
            r_state    <= S_WAIT;
          end else begin
            r_instr_count <= sat_inc(r_instr_count);
            r_pc          <= w_branch_taken ? Target : w_pc_inc;
          end
        end
        S_WAIT: begin
          r_cycle_count <= sat_inc(r_cycle_count);
          r_wait_cnt    <= r_wait_cnt - 3'd1;
          if (r_wait_cnt == 3'd1) begin
            // Final load cycle: commit and fall through; branch is ignored.
            r_instr_count <= sat_inc(r_instr_count);
            r_pc          <= w_pc_inc;
            r_state       <= S_RUN;
          end
        end
        S_DONE: begin
          if (Start) begin
            r_ack         <= 1'b0;
            r_pc          <= START_C;
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
            r_state       <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign PC          = r_pc;
  assign Commit      = w_commit;
  assign Ack         = r_ack;
  assign Cycle_Count = r_cycle_count;
  assign Instr_Count = r_instr_count;

endmodule
